// File: rtl/lsu_axil_pkg.sv
// Shared types and helpers for the LSU AXI4-Lite master and its load-alignment datapath.
package lsu_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RESP    = 3'd5
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      SZ_B:    strb = 4'b0001 << off;
      SZ_H:    strb = 4'b0011 << off;
      SZ_W:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // An illegal size is reported as not issuable, the same as a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle shared by the LSU master, the crossbar and the slaves.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half from a bus word and sign- or zero-extends it.
module lsu_load_align
  import lsu_axil_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data_o
);

  logic [31:0] shifted_s;

  // Right-justify the addressed lane, then extend it to a full word.
  always_comb begin
    shifted_s = rdata >> {addr_lo, 3'b000};
    case (size)
      SZ_B: data_o = is_unsigned ? {24'h000000, shifted_s[7:0]}
                                 : {{24{shifted_s[7]}}, shifted_s[7:0]};
      SZ_H: data_o = is_unsigned ? {16'h0000, shifted_s[15:0]}
                                 : {{16{shifted_s[15]}}, shifted_s[15:0]};
      SZ_W: data_o = shifted_s;
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_axil_master.sv
// Single-outstanding AXI4-Lite initiator for LSU loads/stores with sizing,
// strobe generation, load extension and local rejection of misaligned accesses.
module lsu_axil_master
  import lsu_axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  axi_lite_if.master        m
);

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] load_data_s;

  lsu_load_align u_align (
    .rdata       (m.rdata),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .data_o      (load_data_s)
  );

  // Next-state and datapath updates for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          wdata_d    = req_wdata << {req_addr[1:0], 3'b000};
          wstrb_d    = gen_wstrb(req_size, req_addr[1:0]);
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          rdata_d    = '0;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = req_we ? ST_WR : ST_RD_ADDR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (m.arready) begin
          state_d = ST_RD_DATA;
        end else begin
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (m.rvalid) begin
          rdata_d = (m.rresp == AXI_RESP_OKAY) ? load_data_s : '0;
          err_d   = (m.rresp != AXI_RESP_OKAY);
          state_d = ST_RESP;
        end else begin
          state_d = ST_RD_DATA;
        end
      end
      // aw and w complete independently; a handshake only counts while its valid is up.
      ST_WR: begin
        aw_done_d = aw_done_q | m.awready;
        w_done_d  = w_done_q | m.wready;
        if (aw_done_d && w_done_d) begin
          state_d = ST_WR_RESP;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR_RESP: begin
        if (m.bvalid) begin
          err_d   = (m.bresp != AXI_RESP_OKAY);
          state_d = ST_RESP;
        end else begin
          state_d = ST_WR_RESP;
        end
      end
      ST_RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 4'b0000;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign m.araddr  = addr_q;
  assign m.arvalid = (state_q == ST_RD_ADDR);
  assign m.rready  = (state_q == ST_RD_DATA);
  assign m.awaddr  = addr_q;
  assign m.awvalid = (state_q == ST_WR) && !aw_done_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = wstrb_q;
  assign m.wvalid  = (state_q == ST_WR) && !w_done_q;
  assign m.bready  = (state_q == ST_WR_RESP);

endmodule

// File: tb/tb_lsu_axil_master.sv
// Directed bench for lsu_axil_master; the AXI slave side is driven cycle by cycle.
module tb_lsu_axil_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  int          n_checks = 0;
  int          n_fail   = 0;

  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  lsu_axil_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .m            (axi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rdata, input logic [1:0] rresp,
                         input logic [31:0] exp_data, input logic exp_err);
    issue(1'b0, addr, size, uns, 32'h0000_0000);
    chk({tag, ".c0_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk({tag, ".c1_arvalid"}, 32'(axi.arvalid), 32'd1);
    chk({tag, ".c1_araddr"}, axi.araddr, addr);
    chk({tag, ".c1_ready"}, 32'(req_ready), 32'd0);
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk({tag, ".c2_arvalid"}, 32'(axi.arvalid), 32'd0);
    chk({tag, ".c2_rready"}, 32'(axi.rready), 32'd1);
    axi.rvalid = 1'b1; axi.rdata = rdata; axi.rresp = rresp;
    tick();
    axi.rvalid = 1'b0; axi.rdata = 32'h0000_0000; axi.rresp = 2'b00;
    chk({tag, ".c3_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".c3_rdata"}, resp_rdata, exp_data);
    chk({tag, ".c3_err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, ".c3_rready"}, 32'(axi.rready), 32'd0);
    tick();
    chk({tag, ".c4_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".c4_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_strb, input logic [1:0] bresp, input logic exp_err);
    issue(1'b1, addr, size, 1'b0, wdata);
    tick();
    req_valid = 1'b0;
    chk({tag, ".c1_awvalid"}, 32'(axi.awvalid), 32'd1);
    chk({tag, ".c1_wvalid"}, 32'(axi.wvalid), 32'd1);
    chk({tag, ".c1_awaddr"}, axi.awaddr, addr);
    chk({tag, ".c1_wdata"}, axi.wdata, exp_wdata);
    chk({tag, ".c1_wstrb"}, 32'(axi.wstrb), 32'(exp_strb));
    axi.awready = 1'b1; axi.wready = 1'b1;
    tick();
    axi.awready = 1'b0; axi.wready = 1'b0;
    chk({tag, ".c2_awvalid"}, 32'(axi.awvalid), 32'd0);
    chk({tag, ".c2_wvalid"}, 32'(axi.wvalid), 32'd0);
    chk({tag, ".c2_bready"}, 32'(axi.bready), 32'd1);
    axi.bvalid = 1'b1; axi.bresp = bresp;
    tick();
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    chk({tag, ".c3_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".c3_err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, ".c3_rdata"}, resp_rdata, 32'h0000_0000);
    chk({tag, ".c3_bready"}, 32'(axi.bready), 32'd0);
    tick();
    chk({tag, ".c4_resp_valid"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic do_local_err(input string tag, input logic we, input logic [31:0] addr,
                              input logic [1:0] size);
    issue(we, addr, size, 1'b0, 32'h1111_1111);
    tick();
    req_valid = 1'b0;
    chk({tag, ".c1_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".c1_err"}, 32'(resp_err), 32'd1);
    chk({tag, ".c1_rdata"}, resp_rdata, 32'h0000_0000);
    chk({tag, ".c1_no_bus"}, {29'd0, axi.arvalid, axi.awvalid, axi.wvalid}, 32'd0);
    tick();
    chk({tag, ".c2_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".c2_no_bus"}, {29'd0, axi.arvalid, axi.awvalid, axi.wvalid}, 32'd0);
    chk({tag, ".c2_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0000_0000; req_wdata = 32'h0000_0000;
    req_size = 2'd0; req_unsigned = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'h0000_0000; axi.rresp = 2'b00;
    tick();
    tick();
    reset = 1'b0;

    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.valids", {27'd0, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 32'd0);
    chk("rst.resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst.rdata", resp_rdata, 32'h0000_0000);

    do_load("ld_word", 32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0);
    do_load("ld_sbyte", 32'h8000_0003, 2'd0, 1'b0, 32'h80FF_0000, 2'b00, 32'hFFFF_FF80, 1'b0);
    do_load("ld_ubyte", 32'h8000_0003, 2'd0, 1'b1, 32'h80FF_0000, 2'b00, 32'h0000_0080, 1'b0);
    do_load("ld_shalf", 32'h8000_0002, 2'd1, 1'b0, 32'h8001_0000, 2'b00, 32'hFFFF_8001, 1'b0);
    do_load("ld_uhalf", 32'h8000_0002, 2'd1, 1'b1, 32'h8001_0000, 2'b00, 32'h0000_8001, 1'b0);
    do_load("ld_byte1", 32'h8000_0001, 2'd0, 1'b0, 32'h1234_5678, 2'b00, 32'h0000_0056, 1'b0);
    do_load("ld_buserr", 32'h8000_0008, 2'd2, 1'b0, 32'hCAFE_F00D, 2'b10, 32'h0000_0000, 1'b1);

    do_store("st_uart", 32'hA000_03F8, 2'd0, 32'h0000_0041, 32'h0000_0041, 4'b0001, 2'b00, 1'b0);
    do_store("st_byte2", 32'h8000_0006, 2'd0, 32'h0000_00AB, 32'h00AB_0000, 4'b0100, 2'b00, 1'b0);
    do_store("st_word_err", 32'h1000_0000, 2'd2, 32'h5555_AAAA, 32'h5555_AAAA, 4'b1111, 2'b10, 1'b1);

    // Split write: awready in cycle 1, wready held off until cycle 4.
    issue(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_1234);
    tick();
    req_valid = 1'b0;
    chk("split.c1_awvalid", 32'(axi.awvalid), 32'd1);
    chk("split.c1_wvalid", 32'(axi.wvalid), 32'd1);
    chk("split.c1_wdata", axi.wdata, 32'h1234_0000);
    chk("split.c1_wstrb", 32'(axi.wstrb), 32'h0000_000C);
    axi.awready = 1'b1;
    tick();
    axi.awready = 1'b0;
    chk("split.c2_awvalid", 32'(axi.awvalid), 32'd0);
    chk("split.c2_wvalid", 32'(axi.wvalid), 32'd1);
    tick();
    chk("split.c3_wvalid", 32'(axi.wvalid), 32'd1);
    chk("split.c3_bready", 32'(axi.bready), 32'd0);
    tick();
    chk("split.c4_wvalid", 32'(axi.wvalid), 32'd1);
    chk("split.c4_wdata", axi.wdata, 32'h1234_0000);
    axi.wready = 1'b1;
    tick();
    axi.wready = 1'b0;
    chk("split.c5_wvalid", 32'(axi.wvalid), 32'd0);
    chk("split.c5_bready", 32'(axi.bready), 32'd1);
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    tick();
    axi.bvalid = 1'b0;
    chk("split.c6_bready", 32'(axi.bready), 32'd0);
    chk("split.c6_resp_valid", 32'(resp_valid), 32'd1);
    chk("split.c6_err", 32'(resp_err), 32'd0);
    tick();
    chk("split.c7_resp_valid", 32'(resp_valid), 32'd0);

    do_local_err("err_ld_word", 1'b0, 32'h8000_0002, 2'd2);
    do_local_err("err_st_half", 1'b1, 32'h8000_0001, 2'd1);
    do_local_err("err_size3", 1'b1, 32'h8000_0000, 2'd3);

    // Reset while waiting in RD_DATA.
    issue(1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'h0000_0000);
    tick();
    req_valid = 1'b0;
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("rstmid.c2_rready", 32'(axi.rready), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid.c3_valids", {29'd0, axi.arvalid, axi.rready, resp_valid}, 32'd0);
    chk("rstmid.c3_ready", 32'(req_ready), 32'd1);
    tick();
    chk("rstmid.c4_resp_valid", 32'(resp_valid), 32'd0);
    do_load("ld_after_rst", 32'h8000_0008, 2'd2, 1'b0, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
